// File: rtl/wb_pipe_reg_pkg.sv
// Shared definitions for the MEM->WB pipeline register and its stage slot.
//
// Purpose:
//   Default field widths, the field values that make up a bubble, and the
//   write-enable helper used to qualify the register-file write port.
//   The same constants serve the other pipeline registers of the core.
package wb_pipe_reg_pkg;

    // Default widths for the 16-bit core.
    localparam int WB_DATA_W  = 16;
    localparam int WB_RADDR_W = 4;

    // Control-field values carried by a bubble. The destination of a bubble
    // is the all-ones NOP register address, which depends on the address width
    // and is therefore supplied as a module parameter.
    localparam logic BUBBLE_VALID    = 1'b0;
    localparam logic BUBBLE_MEMTOREG = 1'b0;
    localparam logic BUBBLE_REGWRITE = 1'b0;

    // A register-file write happens only for a real instruction that asks
    // to write and does not target the NOP destination.
    function automatic logic wb_write_en(input logic valid,
                                         input logic regwrite,
                                         input logic is_nop_dst);
        return valid & regwrite & ~is_nop_dst;
    endfunction

endpackage

// File: rtl/wb_pipe_slot.sv
// One stage of the MEM->WB pipeline register.
//
// Purpose:
//   Holds one instruction slot. Per clock edge, in priority order:
//   reset or flush -> bubble, stall -> hold, otherwise load the incoming slot.
//   An incoming slot with i_valid = 0 is loaded as a bubble whatever its
//   other fields carry, so stray control bits never travel down the pipe.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   i_flush         replace this stage with a bubble
//   i_stall         hold this stage
//   i_valid..i_memres   incoming slot (from the MEM stage or the previous stage)
//   o_valid..o_memres   registered contents of this stage
module wb_pipe_slot
    import wb_pipe_reg_pkg::*;
#(
    parameter int                 DATA_W    = WB_DATA_W,
    parameter int                 RADDR_W   = WB_RADDR_W,
    parameter logic [RADDR_W-1:0] NOP_RADDR = {RADDR_W{1'b1}}
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_flush,
    input  logic               i_stall,
    input  logic               i_valid,
    input  logic               i_memtoreg,
    input  logic [RADDR_W-1:0] i_regdst,
    input  logic               i_regwrite,
    input  logic [DATA_W-1:0]  i_alures,
    input  logic [DATA_W-1:0]  i_memres,
    output logic               o_valid,
    output logic               o_memtoreg,
    output logic [RADDR_W-1:0] o_regdst,
    output logic               o_regwrite,
    output logic [DATA_W-1:0]  o_alures,
    output logic [DATA_W-1:0]  o_memres
);

    logic               r_valid;
    logic               r_memtoreg;
    logic [RADDR_W-1:0] r_regdst;
    logic               r_regwrite;
    logic [DATA_W-1:0]  r_alures;
    logic [DATA_W-1:0]  r_memres;

    always_ff @(posedge CLK) begin
        if (RST || i_flush || (!i_stall && !i_valid)) begin
            r_valid    <= BUBBLE_VALID;
            r_memtoreg <= BUBBLE_MEMTOREG;
            r_regdst   <= NOP_RADDR;
            r_regwrite <= BUBBLE_REGWRITE;
            r_alures   <= '0;
            r_memres   <= '0;
        end else if (!i_stall) begin
            r_valid    <= i_valid;
            r_memtoreg <= i_memtoreg;
            r_regdst   <= i_regdst;
            r_regwrite <= i_regwrite;
            r_alures   <= i_alures;
            r_memres   <= i_memres;
        end
    end

    assign o_valid    = r_valid;
    assign o_memtoreg = r_memtoreg;
    assign o_regdst   = r_regdst;
    assign o_regwrite = r_regwrite;
    assign o_alures   = r_alures;
    assign o_memres   = r_memres;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with STAGES-deep latency.
//
// Purpose:
//   Carries the memory-stage result to the register-file write port and the
//   forwarding unit. Adds valid tracking, stall (hold all stages) and flush
//   (bubble all stages) control, a write-back data mux and write enable driven
//   from the final stage, and a count of instructions committed from it.
//   Every output is a function of registers only; no input reaches an output
//   combinationally. STAGES is legal from 1 to 4.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   stall_i, flush_i    hold / bubble every stage (flush wins)
//   valid_i..memres_i   incoming instruction slot from MEM
//   valid_o..memres_o   final-stage slot
//   wbdata_o            memtoreg_o ? memres_o : alures_o
//   wbwe_o              valid_o & regwrite_o & (regdst_o != NOP_RADDR)
//   retired_o           committed-instruction counter, wraps at 2^CNT_W
module wb_pipe_reg
    import wb_pipe_reg_pkg::*;
#(
    parameter int                 DATA_W    = WB_DATA_W,
    parameter int                 RADDR_W   = WB_RADDR_W,
    parameter logic [RADDR_W-1:0] NOP_RADDR = {RADDR_W{1'b1}},
    parameter int                 STAGES    = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic               memtoreg_i,
    input  logic [RADDR_W-1:0] regdst_i,
    input  logic               regwrite_i,
    input  logic [DATA_W-1:0]  alures_i,
    input  logic [DATA_W-1:0]  memres_i,
    output logic               valid_o,
    output logic               memtoreg_o,
    output logic [RADDR_W-1:0] regdst_o,
    output logic               regwrite_o,
    output logic [DATA_W-1:0]  alures_o,
    output logic [DATA_W-1:0]  memres_o,
    output logic [DATA_W-1:0]  wbdata_o,
    output logic               wbwe_o,
    output logic [CNT_W-1:0]   retired_o
);

    // Per-stage slot inputs and registered slot contents.
    logic               w_in_valid    [STAGES];
    logic               w_in_memtoreg [STAGES];
    logic [RADDR_W-1:0] w_in_regdst   [STAGES];
    logic               w_in_regwrite [STAGES];
    logic [DATA_W-1:0]  w_in_alures   [STAGES];
    logic [DATA_W-1:0]  w_in_memres   [STAGES];

    logic               w_valid    [STAGES];
    logic               w_memtoreg [STAGES];
    logic [RADDR_W-1:0] w_regdst   [STAGES];
    logic               w_regwrite [STAGES];
    logic [DATA_W-1:0]  w_alures   [STAGES];
    logic [DATA_W-1:0]  w_memres   [STAGES];

    logic               w_advance;
    logic [CNT_W-1:0]   r_retired;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_in_valid[s]    = valid_i;
            assign w_in_memtoreg[s] = memtoreg_i;
            assign w_in_regdst[s]   = regdst_i;
            assign w_in_regwrite[s] = regwrite_i;
            assign w_in_alures[s]   = alures_i;
            assign w_in_memres[s]   = memres_i;
        end else begin : g_body
            assign w_in_valid[s]    = w_valid[s-1];
            assign w_in_memtoreg[s] = w_memtoreg[s-1];
            assign w_in_regdst[s]   = w_regdst[s-1];
            assign w_in_regwrite[s] = w_regwrite[s-1];
            assign w_in_alures[s]   = w_alures[s-1];
            assign w_in_memres[s]   = w_memres[s-1];
        end

        wb_pipe_slot #(
            .DATA_W   (DATA_W),
            .RADDR_W  (RADDR_W),
            .NOP_RADDR(NOP_RADDR)
        ) u_slot (
            .CLK       (CLK),
            .RST       (RST),
            .i_flush   (flush_i),
            .i_stall   (stall_i),
            .i_valid   (w_in_valid[s]),
            .i_memtoreg(w_in_memtoreg[s]),
            .i_regdst  (w_in_regdst[s]),
            .i_regwrite(w_in_regwrite[s]),
            .i_alures  (w_in_alures[s]),
            .i_memres  (w_in_memres[s]),
            .o_valid   (w_valid[s]),
            .o_memtoreg(w_memtoreg[s]),
            .o_regdst  (w_regdst[s]),
            .o_regwrite(w_regwrite[s]),
            .o_alures  (w_alures[s]),
            .o_memres  (w_memres[s])
        );
    end

    // The final-stage entry leaves the pipe whenever the pipe moves. A flush
    // also moves it: that entry has already been committed to write-back, so
    // it is counted even though the stage is overwritten with a bubble.
    assign w_advance = ~stall_i | flush_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_retired <= '0;
        end else if (w_advance && w_valid[STAGES-1]) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign valid_o    = w_valid[STAGES-1];
    assign memtoreg_o = w_memtoreg[STAGES-1];
    assign regdst_o   = w_regdst[STAGES-1];
    assign regwrite_o = w_regwrite[STAGES-1];
    assign alures_o   = w_alures[STAGES-1];
    assign memres_o   = w_memres[STAGES-1];

    assign wbdata_o   = w_memtoreg[STAGES-1] ? w_memres[STAGES-1] : w_alures[STAGES-1];
    assign wbwe_o     = wb_write_en(w_valid[STAGES-1], w_regwrite[STAGES-1],
                                    w_regdst[STAGES-1] == NOP_RADDR);
    assign retired_o  = r_retired;

endmodule
